// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic sensor conditioning stage.
// Debouncer state enum is only used when SENSOR_DEBOUNCE_EN is defined.
package traffic_pkg;

   localparam int COUNT_WIDTH = 4;
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = 4'd15;

   localparam int NUM_STREETS = 2;
   localparam int STREET_H    = 0;
   localparam int STREET_V    = 1;

   typedef enum logic [1:0] {
      LOW,
      RISE_WAIT,
      HIGH,
      FALL_WAIT
   } deb_state_e;

   // Saturating increment of a per-street vehicle count.
   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (v == COUNT_MAX) ? COUNT_MAX : v + COUNT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/traffic_sensor_counter_debouncer.sv
// Per-street conditioning: 2-flop synchronizer, optional debounce FSM
// (SENSOR_DEBOUNCE_EN) and a one-cycle pulse per detected vehicle arrival.
module sensor_debouncer
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic sensor_raw,
   output logic rise_pulse
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be >= 1");
   end

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   always_comb begin
      sync1_d = sensor_raw;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

`ifdef SENSOR_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(DEBOUNCE_CYCLES);

   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q holds the number of consecutive samples seen at the opposite level;
   // the level flips on the next agreeing sample once it reaches the target.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rise_pulse = 1'b0;
      case (state_q)
         LOW: begin
            if (sync2_q) begin
               state_d = RISE_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         RISE_WAIT: begin
            if (!sync2_q) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_TGT) begin
               state_d    = HIGH;
               cnt_d      = '0;
               rise_pulse = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!sync2_q) begin
               state_d = FALL_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         FALL_WAIT: begin
            if (sync2_q) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_TGT) begin
               state_d = LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   logic prev_q, prev_d;

   always_comb begin
      prev_d     = sync2_q;
      rise_pulse = sync2_q & ~prev_q;
   end

   always_ff @(posedge clock) begin
      if (reset) prev_q <= 1'b0;
      else       prev_q <= prev_d;
   end
`endif

endmodule

// File: rtl/traffic_sensor_counter.sv
// Vehicle arrival counter for both streets over a fixed sampling window.
// Debouncing is enabled by defining SENSOR_DEBOUNCE_EN.
module traffic_sensor_counter
   import traffic_pkg::*;
#(
   parameter int WINDOW_CYCLES   = 1000,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       sensor_Street_0,
   input  logic       sensor_Street_1,
   input  logic       police_Interrupt,
   output logic [3:0] traffic_Street_0,
   output logic [3:0] traffic_Street_1,
   output logic       count_Valid,
   output logic [1:0] overflow
);

   if (WINDOW_CYCLES < 2) begin : g_bad_window
      $error("WINDOW_CYCLES must be >= 2");
   end

   localparam int WIN_W = $clog2(WINDOW_CYCLES);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

   logic [NUM_STREETS-1:0] sensor_raw;
   logic [NUM_STREETS-1:0] rise;

   assign sensor_raw[STREET_H] = sensor_Street_0;
   assign sensor_raw[STREET_V] = sensor_Street_1;

   for (genvar i = 0; i < NUM_STREETS; i++) begin : g_street
      sensor_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clock     (clock),
         .reset     (reset),
         .sensor_raw(sensor_raw[i]),
         .rise_pulse(rise[i])
      );
   end

   logic [NUM_STREETS-1:0][COUNT_WIDTH-1:0] acc_q, acc_d, acc_upd;
   logic [NUM_STREETS-1:0][COUNT_WIDTH-1:0] traffic_q, traffic_d;
   logic [NUM_STREETS-1:0]                  sat_q, sat_d, sat_upd;
   logic [NUM_STREETS-1:0]                  ovf_q, ovf_d;
   logic [WIN_W-1:0]                        win_q, win_d;
   logic                                    valid_q, valid_d;
   logic                                    terminal;

   always_comb begin
      acc_upd   = acc_q;
      sat_upd   = sat_q;
      acc_d     = acc_q;
      sat_d     = sat_q;
      traffic_d = traffic_q;
      ovf_d     = ovf_q;
      win_d     = win_q;
      valid_d   = 1'b0;
      terminal  = (win_q == WIN_LAST) && !police_Interrupt;

      for (int i = 0; i < NUM_STREETS; i++) begin
         if (rise[i]) begin
            acc_upd[i] = sat_inc(acc_q[i]);
            if (acc_q[i] == COUNT_MAX) sat_upd[i] = 1'b1;
         end
      end

      acc_d = acc_upd;
      sat_d = sat_upd;

      // Publish uses the updated values so a vehicle on the terminal cycle lands in this window.
      if (terminal) begin
         traffic_d = acc_upd;
         ovf_d     = sat_upd;
         valid_d   = 1'b1;
         acc_d     = '0;
         sat_d     = '0;
         win_d     = '0;
      end else if (!police_Interrupt) begin
         win_d = win_q + WIN_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q     <= '0;
         sat_q     <= '0;
         traffic_q <= '0;
         ovf_q     <= '0;
         win_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         sat_q     <= sat_d;
         traffic_q <= traffic_d;
         ovf_q     <= ovf_d;
         win_q     <= win_d;
         valid_q   <= valid_d;
      end
   end

   assign traffic_Street_0 = traffic_q[STREET_H];
   assign traffic_Street_1 = traffic_q[STREET_V];
   assign count_Valid      = valid_q;
   assign overflow         = ovf_q;

endmodule

// File: tb/tb_traffic_sensor_counter.sv
// Bench for traffic_sensor_counter: window-level vector table, hand-written
// timing corners, and random traffic checked against a run-length reference model.
module tb_traffic_sensor_counter;

   localparam int W = 200;
   localparam int D = 3;
`ifdef SENSOR_DEBOUNCE_EN
   localparam int LAT        = D + 2;
   localparam int GLITCH_EXP = 0;
`else
   localparam int LAT        = 2;
   localparam int GLITCH_EXP = 1;
`endif

   logic       clock = 1'b0;
   logic       reset, s0, s1, pol;
   logic [3:0] traffic_Street_0, traffic_Street_1;
   logic       count_Valid;
   logic [1:0] overflow;

   traffic_sensor_counter #(.WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(D)) dut (
      .clock           (clock),
      .reset           (reset),
      .sensor_Street_0 (s0),
      .sensor_Street_1 (s1),
      .police_Interrupt(pol),
      .traffic_Street_0(traffic_Street_0),
      .traffic_Street_1(traffic_Street_1),
      .count_Valid     (count_Valid),
      .overflow        (overflow)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int pub_cyc  = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference model: raw input delayed two edges, filtered level flips after
   // D+1 consecutive disagreeing samples (or every 0->1 without debouncing).
   int m_d1[2], m_d2[2], m_prev[2], m_filt[2], m_run[2];
   int m_acc[2], m_sat[2], m_t[2], m_ovf, m_valid, m_win;

   task automatic model_update();
      int raw[2];
      int samp, veh;
      raw[0] = int'(s0);
      raw[1] = int'(s1);
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_d1[i] = 0; m_d2[i] = 0; m_prev[i] = 0; m_filt[i] = 0; m_run[i] = 0;
            m_acc[i] = 0; m_sat[i] = 0; m_t[i] = 0;
         end
         m_ovf = 0; m_valid = 0; m_win = 0;
         return;
      end
      for (int i = 0; i < 2; i++) begin
         samp    = m_d2[i];
         m_d2[i] = m_d1[i];
         m_d1[i] = raw[i];
`ifdef SENSOR_DEBOUNCE_EN
         veh = 0;
         if (samp != m_filt[i]) m_run[i]++;
         else m_run[i] = 0;
         if (m_run[i] == D + 1) begin
            m_filt[i] = samp;
            m_run[i]  = 0;
            veh       = samp;
         end
`else
         veh       = (samp == 1 && m_prev[i] == 0) ? 1 : 0;
         m_prev[i] = samp;
`endif
         if (veh != 0) begin
            if (m_acc[i] == 15) m_sat[i] = 1;
            else m_acc[i]++;
         end
      end
      m_valid = 0;
      if (!pol) begin
         if (m_win == W - 1) begin
            m_t[0] = m_acc[0]; m_t[1] = m_acc[1];
            m_ovf  = m_sat[0] + 2 * m_sat[1];
            m_acc[0] = 0; m_acc[1] = 0; m_sat[0] = 0; m_sat[1] = 0;
            m_valid = 1;
            m_win   = 0;
         end else begin
            m_win++;
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_update();
      cyc++;
      #1;
      check("model", int'({traffic_Street_0, traffic_Street_1, count_Valid, overflow}),
            m_t[0] * 128 + m_t[1] * 8 + m_valid * 4 + m_ovf);
   endtask

   task automatic wait_valid(input int maxc, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!count_Valid && cnt < maxc);
      check("valid_seen", int'(count_Valid), 1);
      pub_cyc = cyc;
   endtask

   task automatic pulses(input int n, input bit st, input int hi, input int lo);
      for (int p = 0; p < n; p++) begin
         if (st) s1 = 1'b1; else s0 = 1'b1;
         repeat (hi) step();
         s0 = 1'b0; s1 = 1'b0;
         repeat (lo) step();
      end
   endtask

   typedef struct {
      int n0, n1, hi, lo;
      bit glitch;
      int e0, e1, eov;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int cnt, prev, rel, vcnt, np;
      tbl[0] = '{0,  0, 8, 8, 1'b0, 0, 0, 0};
      tbl[1] = '{3,  0, 8, 8, 1'b0, 3, 0, 0};
      tbl[2] = '{0,  0, 8, 8, 1'b1, 0, GLITCH_EXP, 0};
      tbl[3] = '{17, 0, 5, 5, 1'b0, 15, 0, 1};
      tbl[4] = '{2,  0, 8, 8, 1'b0, 2, 0, 0};
      tbl[5] = '{4,  6, 5, 5, 1'b0, 4, 6, 0};
      tbl[6] = '{0, 16, 5, 5, 1'b0, 0, 15, 2};
      tbl[7] = '{0, 15, 5, 5, 1'b0, 0, 15, 0};

      reset = 1'b1; s0 = 1'b0; s1 = 1'b0; pol = 1'b0;
      repeat (3) step();
      check("reset_outputs", int'({traffic_Street_0, traffic_Street_1, count_Valid, overflow}), 0);
      reset = 1'b0;
      wait_valid(W + 50, cnt);
      check("first_valid_latency", cnt, W);
      check("idle_t0", int'(traffic_Street_0), 0);
      check("idle_t1", int'(traffic_Street_1), 0);
      check("idle_ovf", int'(overflow), 0);

      foreach (tbl[r]) begin
         prev = pub_cyc;
         np = (tbl[r].n0 > tbl[r].n1) ? tbl[r].n0 : tbl[r].n1;
         for (int p = 0; p < np; p++) begin
            s0 = (p < tbl[r].n0);
            s1 = (p < tbl[r].n1);
            repeat (tbl[r].hi) step();
            s0 = 1'b0; s1 = 1'b0;
            repeat (tbl[r].lo) step();
         end
         if (tbl[r].glitch) begin
            s1 = 1'b1; repeat (2) step(); s1 = 1'b0;
         end
         wait_valid(W + 50, cnt);
         check($sformatf("vec%0d_period", r), pub_cyc - prev, W);
         check($sformatf("vec%0d_t0", r), int'(traffic_Street_0), tbl[r].e0);
         check($sformatf("vec%0d_t1", r), int'(traffic_Street_1), tbl[r].e1);
         check($sformatf("vec%0d_ovf", r), int'(overflow), tbl[r].eov);
      end

      // Vehicle whose increment lands exactly on the terminal edge.
      repeat (W - 1 - LAT) step();
      s0 = 1'b1;
      wait_valid(20, cnt);
      check("lat_on_terminal_t0", int'(traffic_Street_0), 1);
      repeat (4) step();
      s0 = 1'b0;
      wait_valid(W + 50, cnt);
      check("lat_on_terminal_next", int'(traffic_Street_0), 0);

      // One cycle later it belongs to the following window.
      repeat (W - LAT) step();
      s0 = 1'b1;
      wait_valid(20, cnt);
      check("lat_after_terminal_t0", int'(traffic_Street_0), 0);
      repeat (4) step();
      s0 = 1'b0;
      wait_valid(W + 50, cnt);
      check("lat_after_terminal_next", int'(traffic_Street_0), 1);

      // Police hold mid-window with a vehicle during the hold.
      prev = pub_cyc;
      repeat (50) step();
      pol = 1'b1;
      repeat (3) step();
      s0 = 1'b1; repeat (5) step(); s0 = 1'b0;
      repeat (2) step();
      pol = 1'b0;
      wait_valid(W + 50, cnt);
      check("hold_period", pub_cyc - prev, W + 10);
      check("hold_vehicle", int'(traffic_Street_0), 1);

      // Hold asserted on the terminal cycle defers the publish.
      prev = pub_cyc;
      repeat (W - 1) step();
      pol = 1'b1;
      vcnt = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (count_Valid) vcnt++;
      end
      check("terminal_hold_no_pulse", vcnt, 0);
      pol = 1'b0;
      wait_valid(3, cnt);
      check("terminal_hold_release", cnt, 1);
      check("terminal_hold_period", pub_cyc - prev, W + 5);

      // Reset mid-window discards partial counts and clears outputs.
      pulses(1, 1'b1, 8, 8);
      wait_valid(W + 50, cnt);
      check("pre_reset_t1", int'(traffic_Street_1), 1);
      pulses(2, 1'b0, 8, 8);
      repeat (10) step();
      reset = 1'b1;
      step();
      check("mid_reset_outputs", int'({traffic_Street_0, traffic_Street_1, count_Valid, overflow}), 0);
      reset = 1'b0;
      rel = cyc;
      pulses(1, 1'b0, 8, 8);
      wait_valid(W + 50, cnt);
      check("post_reset_period", pub_cyc - rel, W);
      check("post_reset_t0", int'(traffic_Street_0), 1);
      check("post_reset_t1", int'(traffic_Street_1), 0);

      // Random traffic, holds and occasional resets against the model.
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 5) == 0) s0 = ~s0;
         if ($urandom_range(0, 4) == 0) s1 = ~s1;
         pol   = ($urandom_range(0, 29) == 0);
         reset = ($urandom_range(0, 999) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
